// File: rtl/nfc_irq.sv
// nfc_irq: APB-controlled, debounced NFC interrupt to fabric with optional event counter.
// Define NFC_IRQ_EVENT_COUNT_EN to build the 16-bit saturating COUNT register.
module nfc_irq #(
   parameter logic [7:0] ADDR_BASE = 8'h28,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        pclk,
   input  logic        nreset,
   input  logic        bus_write_en,
   input  logic        bus_read_en,
   input  logic [7:0]  bus_addr,
   input  logic [31:0] bus_write_data,
   output logic [31:0] bus_read_data,
   input  logic        irq_pin,
   output logic        fabint
);
   localparam logic [7:0] ADDR_CTRL = ADDR_BASE;
   localparam logic [7:0] ADDR_STAT = ADDR_BASE + 8'd4;
   localparam logic [7:0] ADDR_CNT  = ADDR_BASE + 8'd8;
   typedef enum logic [2:0] {IDLE = 3'd0, WAIT = 3'd1, DEBOUNCE = 3'd2, LATCHED = 3'd3, REARM = 3'd4} state_t;
   state_t state;
   logic [1:0] ctrl;
   logic [1:0] sync;
   logic [7:0] cnt;
   logic pending;
   logic asserted, wr_ctrl, wr_stat, disable_wr, clear, qualify;
   logic [31:0] count;
   logic unused_wdata;
   assign asserted = sync[1] ^ ctrl[1];
   assign wr_ctrl = bus_write_en && bus_addr == ADDR_CTRL;
   assign wr_stat = bus_write_en && bus_addr == ADDR_STAT;
   assign disable_wr = wr_ctrl && !bus_write_data[0];
   assign clear = wr_stat && bus_write_data[0];
   assign qualify = state == DEBOUNCE && asserted && cnt == 8'(DEBOUNCE_CYCLES);
   assign fabint = pending;
   assign unused_wdata = ^bus_write_data[31:2];
   always_ff @(posedge pclk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         ctrl    <= 2'b10;
         sync    <= 2'b11;
         cnt     <= 8'd0;
         pending <= 1'b0;
      end else begin
         sync <= {sync[0], irq_pin};
         if (wr_ctrl) ctrl <= bus_write_data[1:0];
         if (disable_wr) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            pending <= 1'b0;
         end else begin
            // qualification beats a simultaneous clear
            pending <= qualify || (pending && !clear);
            case (state)
               IDLE:     if (ctrl[0]) state <= WAIT;
               WAIT:     if (asserted) begin
                  cnt   <= 8'd1;
                  state <= DEBOUNCE;
               end
               DEBOUNCE: if (!asserted) state <= WAIT;
                         else if (qualify) state <= LATCHED;
                         else cnt <= cnt + 8'd1;
               LATCHED:  if (clear) state <= REARM;
               REARM:    if (!asserted) state <= WAIT;
               default:  state <= IDLE;
            endcase
         end
      end
   end
`ifdef NFC_IRQ_EVENT_COUNT_EN
   logic [15:0] events;
   always_ff @(posedge pclk or negedge nreset) begin
      if (!nreset) events <= 16'd0;
      else if (bus_write_en && bus_addr == ADDR_CNT) events <= 16'd0;
      else if (qualify && !disable_wr && events != 16'hFFFF) events <= events + 16'd1;
   end
   assign count = {16'h0, events};
`else
   assign count = 32'h0;
`endif
   // STATUS bit1 reports the synchronized pin level itself, before polarity
   always_comb
      bus_read_data = !bus_read_en ? 32'h0 :
                      bus_addr == ADDR_CTRL ? {30'h0, ctrl} :
                      bus_addr == ADDR_STAT ? {27'h0, state, sync[1], pending} :
                      bus_addr == ADDR_CNT  ? count : 32'h0;
endmodule

// File: tb/tb_nfc_irq.sv
// tb_nfc_irq: directed and randomized checks of nfc_irq against a pulse-length event model.
module tb_nfc_irq;
   localparam logic [7:0] CTRL_A = 8'h28, STAT_A = 8'h2C, CNT_A = 8'h30;
   localparam int N = 16;
   logic pclk = 1'b0, nreset, bus_write_en, bus_read_en, irq_pin, fabint;
   logic [7:0] bus_addr;
   logic [31:0] bus_write_data, bus_read_data, v;
   int checks = 0, errors = 0, events = 0;
   nfc_irq #(.ADDR_BASE(8'h28), .DEBOUNCE_CYCLES(N)) dut (
      .pclk(pclk), .nreset(nreset), .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
      .bus_addr(bus_addr), .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
      .irq_pin(irq_pin), .fabint(fabint));
   always #5 pclk = ~pclk;
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus_addr = a;
      bus_write_data = d;
      bus_write_en = 1'b1;
      tick();
      bus_write_en = 1'b0;
   endtask
   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      bus_addr = a;
      bus_read_en = 1'b1;
      #1;
      d = bus_read_data;
      bus_read_en = 1'b0;
   endtask
   function automatic logic [31:0] exp_count(input int n);
`ifdef NFC_IRQ_EVENT_COUNT_EN
      return n;
`else
      return 32'h0 & n;
`endif
   endfunction
   // a pin held asserted for at least N+1 sampled edges latches at edge N+3
   initial begin
      nreset = 1'b0; irq_pin = 1'b0; bus_write_en = 1'b0; bus_read_en = 1'b0;
      bus_addr = 8'h0; bus_write_data = 32'h0;
      tick(2);
      check("reset_fabint", fabint, 0);
      rd(CTRL_A, v); check("reset_ctrl", v, 32'h2);
      rd(STAT_A, v); check("reset_status", v, 32'h2);
      rd(CNT_A, v);  check("reset_count", v, 32'h0);
      #2 nreset = 1'b1;
      tick(5);
      check("release_fabint", fabint, 0);
      rd(STAT_A, v); check("release_status", v, 32'h0);
      irq_pin = 1'b1;
      tick(2);
      wr(CTRL_A, 32'h3);
      tick(2);
      rd(CTRL_A, v); check("ctrl_rw", v, 32'h3);
      rd(STAT_A, v); check("wait_status", v, 32'h6);
      wr(8'h29, 32'h0);
      rd(CTRL_A, v); check("unmatched_write", v, 32'h3);
      rd(8'h34, v);  check("unmatched_read", v, 32'h0);
      bus_addr = CTRL_A; #1;
      check("no_read_en", bus_read_data, 32'h0);
      irq_pin = 1'b0;
      tick(18);
      check("edge18_fabint", fabint, 0);
      tick();
      events++;
      check("edge19_fabint", fabint, 1);
      rd(STAT_A, v); check("latched_status", v, 32'hD);
      wr(STAT_A, 32'h1);
      check("clear_fabint", fabint, 0);
      tick(3);
      rd(STAT_A, v); check("rearm_status", v, 32'h10);
      check("rearm_fabint", fabint, 0);
      irq_pin = 1'b1;
      tick(4);
      rd(STAT_A, v); check("rearm_to_wait", v, 32'h6);
      irq_pin = 1'b0;
      tick(18);
      check("second_edge18", fabint, 0);
      tick();
      events++;
      check("second_event", fabint, 1);
      tick();
      irq_pin = 1'b1;
      wr(STAT_A, 32'h1);
      tick(4);
      rd(STAT_A, v); check("second_rearm", v, 32'h6);
      irq_pin = 1'b0;
      tick(10);
      rd(STAT_A, v); check("short_debounce", v, 32'h8);
      irq_pin = 1'b1;
      tick(4);
      check("short_fabint", fabint, 0);
      rd(STAT_A, v); check("short_to_wait", v, 32'h6);
      irq_pin = 1'b0;
      tick(18);
      wr(STAT_A, 32'h1);
      events++;
      check("race_fabint", fabint, 1);
      rd(STAT_A, v); check("race_status", v, 32'hD);
      rd(CNT_A, v); check("count_three", v, exp_count(events));
      wr(CNT_A, 32'h5A);
      events = 0;
      rd(CNT_A, v); check("count_cleared", v, 32'h0);
      irq_pin = 1'b1;
      wr(STAT_A, 32'h1);
      tick(4);
      for (int it = 0; it < 8; it++) begin
         int len;
         bit fired;
         len = it == 0 ? N : it == 1 ? N + 1 : int'($urandom_range(4, 30));
         fired = len >= N + 1;
         irq_pin = 1'b0;
         for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == len) irq_pin = 1'b1;
            check("rand_fabint", fabint, {31'h0, fired && k >= N + 3});
         end
         irq_pin = 1'b1;
         if (fired) begin
            wr(STAT_A, 32'h1);
            events++;
         end
         tick(4);
         rd(STAT_A, v); check("rand_wait", v, 32'h6);
      end
      rd(CNT_A, v); check("rand_count", v, exp_count(events));
      irq_pin = 1'b0;
      tick(19);
      events++;
      check("pre_disable", fabint, 1);
      wr(CTRL_A, 32'h2);
      check("disable_fabint", fabint, 0);
      rd(STAT_A, v); check("disable_status", v, 32'h0);
      rd(CNT_A, v); check("disable_count", v, exp_count(events));
      irq_pin = 1'b1;
      tick(2);
      wr(CTRL_A, 32'h3);
      tick(2);
      irq_pin = 1'b0;
      tick(8);
      rd(STAT_A, v); check("pre_reset_debounce", v, 32'h8);
      #2 nreset = 1'b0;
      #1 check("rst_deb_fabint", fabint, 0);
      rd(CTRL_A, v); check("rst_deb_ctrl", v, 32'h2);
      rd(STAT_A, v); check("rst_deb_status", v, 32'h2);
      nreset = 1'b1;
      events = 0;
      irq_pin = 1'b1;
      tick(3);
      wr(CTRL_A, 32'h3);
      tick(2);
      irq_pin = 1'b0;
      tick(19);
      check("pre_reset_latched", fabint, 1);
      #2 nreset = 1'b0;
      #1 check("rst_lat_fabint", fabint, 0);
      rd(CTRL_A, v); check("rst_lat_ctrl", v, 32'h2);
      rd(STAT_A, v); check("rst_lat_status", v, 32'h2);
      nreset = 1'b1;
      irq_pin = 1'b1;
      tick(3);
      rd(CNT_A, v); check("rst_count", v, 32'h0);
      check("final_fabint", fabint, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
